// File: rtl/oka_4bit_subproduct_seq.sv
// OKA 4-bit stage front end: splits operands into even/odd halves and
// forms the four sub-products with one time-shared 2x2 carry-less core.
module oka_4bit_subproduct_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [2:0] p_ee_o,
  output logic [2:0] p_mid_o,
  output logic [2:0] p_sum_o,
  output logic [2:0] p_oo_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    MUL_EE,
    MUL_OO,
    MUL_MID,
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [2:0] ee_q, ee_d;
  logic [2:0] oo_q, oo_d;
  logic [2:0] mid_q, mid_d;
  logic [2:0] sum_q, sum_d;
  logic       ov_q, ov_d;
  logic       accept;
  logic [1:0] u, v;
  logic [2:0] core;

  assign in_ready_o = (state_q == IDLE) |
                      ((state_q == DONE) & out_ready_i);
  assign accept     = in_valid_i & in_ready_o;
  assign busy_o     = (state_q != IDLE);

  // Route the even, odd or folded halves into the shared core.
  always_comb begin
    u = 2'b00;
    v = 2'b00;
    case (state_q)
      MUL_EE: begin
        u = {a_q[2], a_q[0]};
        v = {b_q[2], b_q[0]};
      end
      MUL_OO: begin
        u = {a_q[3], a_q[1]};
        v = {b_q[3], b_q[1]};
      end
      MUL_MID: begin
        u = {a_q[2] ^ a_q[3], a_q[0] ^ a_q[1]};
        v = {b_q[2] ^ b_q[3], b_q[0] ^ b_q[1]};
      end
      default: begin
        u = 2'b00;
        v = 2'b00;
      end
    endcase
  end

  assign core = {u[1] & v[1],
                 (u[0] & v[1]) ^ (u[1] & v[0]),
                 u[0] & v[0]};

  // Next-state and register updates for the multiply sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ee_d    = ee_q;
    oo_d    = oo_q;
    mid_d   = mid_q;
    sum_d   = sum_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = a_i;
          b_d     = b_i;
          state_d = MUL_EE;
        end
      end
      MUL_EE: begin
        ee_d    = core;
        state_d = MUL_OO;
      end
      MUL_OO: begin
        oo_d    = core;
        state_d = MUL_MID;
      end
      MUL_MID: begin
        mid_d   = core;
        sum_d   = ee_q ^ oo_q;
        ov_d    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready_i) begin
          ov_d = 1'b0;
          if (in_valid_i) begin
            a_d     = a_i;
            b_d     = b_i;
            state_d = MUL_EE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ee_q    <= '0;
      oo_q    <= '0;
      mid_q   <= '0;
      sum_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ee_q    <= ee_d;
      oo_q    <= oo_d;
      mid_q   <= mid_d;
      sum_q   <= sum_d;
      ov_q    <= ov_d;
    end
  end

  assign out_valid_o = ov_q;
  assign p_ee_o      = ee_q;
  assign p_oo_o      = oo_q;
  assign p_mid_o     = mid_q;
  assign p_sum_o     = sum_q;

endmodule

// File: tb/tb_oka_4bit_subproduct_seq.sv
// Bench for oka_4bit_subproduct_seq: directed cases plus a randomized
// scoreboard run against a plain 4x4 carry-less multiply model.
`timescale 1ns/1ps
module tb_oka_4bit_subproduct_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [3:0] a_i, b_i;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [2:0] p_ee_o, p_mid_o, p_sum_o, p_oo_o;
  logic       busy_o;

  int n_pass  = 0;
  int n_total = 0;
  logic mon_en = 1'b0;
  logic [6:0] exp_q[$];

  always #5 clk = ~clk;

  oka_4bit_subproduct_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .a_i(a_i), .b_i(b_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .p_ee_o(p_ee_o), .p_mid_o(p_mid_o),
    .p_sum_o(p_sum_o), .p_oo_o(p_oo_o),
    .busy_o(busy_o)
  );

  function automatic logic [6:0] clmul(input logic [3:0] x,
                                       input logic [3:0] y);
    logic [6:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (y[i]) r = r ^ (7'(x) << i);
    return r;
  endfunction

  function automatic logic [6:0] comb7(input logic [2:0] ee,
                                       input logic [2:0] mid,
                                       input logic [2:0] sm,
                                       input logic [2:0] oo);
    logic [6:0] r;
    r[0] = ee[0];
    r[1] = mid[0] ^ sm[0];
    r[2] = ee[1] ^ oo[0];
    r[3] = mid[1] ^ sm[1];
    r[4] = ee[2] ^ oo[1];
    r[5] = mid[2] ^ sm[2];
    r[6] = oo[2];
    return r;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] dut_comb();
    return comb7(p_ee_o, p_mid_o, p_sum_o, p_oo_o);
  endfunction

  // Start an operation from IDLE and check the 3-edge latency.
  task automatic op_start(input logic [3:0] x, input logic [3:0] y);
    a_i = x;
    b_i = y;
    in_valid_i = 1'b1;
    out_ready_i = 1'b0;
    #1;
    check("start_in_ready", 32'(in_ready_o), 1);
    tick();
    in_valid_i = 1'b0;
    check("accept_busy", 32'(busy_o), 1);
    check("lat_t0", 32'(out_valid_o), 0);
    tick();
    check("lat_t1", 32'(out_valid_o), 0);
    tick();
    check("lat_t2", 32'(out_valid_o), 0);
    tick();
    check("lat_t3", 32'(out_valid_o), 1);
  endtask

  task automatic release_out();
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check("release_ov", 32'(out_valid_o), 0);
    check("release_busy", 32'(busy_o), 0);
  endtask

  // Scoreboard monitor: pops on every output handshake.
  logic        hold = 1'b0;
  logic [11:0] held;
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (busy_o && !out_valid_o)
        check("mul_in_ready", 32'(in_ready_o), 0);
      if (out_valid_o) begin
        if (hold)
          check("stable", 32'({p_ee_o, p_mid_o, p_sum_o, p_oo_o}),
                32'(held));
        if (out_ready_i) begin
          hold = 1'b0;
          if (exp_q.size() == 0) begin
            check("dup_result", 1, 0);
          end else begin
            check("rand_prod", 32'(dut_comb()), 32'(exp_q.pop_front()));
          end
        end else begin
          hold = 1'b1;
          held = {p_ee_o, p_mid_o, p_sum_o, p_oo_o};
        end
      end else begin
        hold = 1'b0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] s_ee, s_mid, s_sum, s_oo;
    logic       acc;
    logic       seen;
    int         accepted;
    int         cyc;

    rst_n = 1'b0;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    a_i = '0;
    b_i = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    check("rst_ov", 32'(out_valid_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_in_ready", 32'(in_ready_o), 1);
    check("rst_p", 32'({p_ee_o, p_mid_o, p_sum_o, p_oo_o}), 0);

    op_start(4'b1011, 4'b0110);
    check("basic_ee", 32'(p_ee_o), 32'(3'b010));
    check("basic_oo", 32'(p_oo_o), 32'(3'b011));
    check("basic_mid", 32'(p_mid_o), 32'(3'b110));
    check("basic_sum", 32'(p_sum_o), 32'(3'b001));
    check("basic_comb", 32'(dut_comb()), 32'(7'b0111010));
    release_out();

    op_start(4'hF, 4'hF);
    check("ones_ee", 32'(p_ee_o), 32'(3'b101));
    check("ones_oo", 32'(p_oo_o), 32'(3'b101));
    check("ones_mid", 32'(p_mid_o), 0);
    check("ones_sum", 32'(p_sum_o), 0);
    check("ones_comb", 32'(dut_comb()), 32'(7'b1010101));
    release_out();

    op_start(4'h3, 4'h5);
    check("bp_first", 32'(dut_comb()), 32'(clmul(4'h3, 4'h5)));
    {s_ee, s_mid, s_sum, s_oo} = {p_ee_o, p_mid_o, p_sum_o, p_oo_o};
    in_valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a_i = 4'(i + 8);
      b_i = 4'hA;
      tick();
      check("bp_stable", 32'({p_ee_o, p_mid_o, p_sum_o, p_oo_o}),
            32'({s_ee, s_mid, s_sum, s_oo}));
      check("bp_ov", 32'(out_valid_o), 1);
      check("bp_in_ready", 32'(in_ready_o), 0);
    end
    a_i = 4'hC;
    b_i = 4'hA;
    out_ready_i = 1'b1;
    #1;
    check("bp_ready_rise", 32'(in_ready_o), 1);
    tick();
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    check("b2b_ov0", 32'(out_valid_o), 0);
    check("b2b_busy", 32'(busy_o), 1);
    tick();
    tick();
    check("b2b_t2", 32'(out_valid_o), 0);
    tick();
    check("b2b_t3", 32'(out_valid_o), 1);
    check("b2b_comb", 32'(dut_comb()), 32'(clmul(4'hC, 4'hA)));
    release_out();

    a_i = 4'h7;
    b_i = 4'h9;
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_ov", 32'(out_valid_o), 0);
    check("mid_rst_busy", 32'(busy_o), 0);
    check("mid_rst_in_ready", 32'(in_ready_o), 1);
    check("mid_rst_p", 32'({p_ee_o, p_mid_o, p_sum_o, p_oo_o}), 0);
    rst_n = 1'b1;
    out_ready_i = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (out_valid_o) seen = 1'b1;
    end
    check("mid_rst_no_ov", 32'(seen), 0);

    mon_en = 1'b1;
    accepted = 0;
    cyc = 0;
    while (accepted < 1000 && cyc < 40000) begin
      @(negedge clk);
      acc = in_valid_i & in_ready_o;
      if (acc) begin
        exp_q.push_back(clmul(a_i, b_i));
        accepted++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (acc || !in_valid_i) begin
        in_valid_i = ($urandom_range(0, 3) != 0);
        a_i = 4'($urandom);
        b_i = 4'($urandom);
      end
      out_ready_i = ($urandom_range(0, 3) != 0);
    end
    in_valid_i = 1'b0;
    check("rand_accepted", accepted, 1000);
    out_ready_i = 1'b1;
    cyc = 0;
    while ((exp_q.size() != 0 || out_valid_o) && cyc < 100) begin
      tick();
      cyc++;
    end
    repeat (2) tick();
    check("rand_drained", exp_q.size(), 0);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
